// File: rtl/gen_call_arbiter_if.sv
// gen_call_arbiter_if: caller-side and generator-side signals of the shared generator arbiter
// GEN_ARB_ABORT_EN adds the per-caller req_abort request.
interface gen_call_arbiter_if #(
  parameter int NREQ = 2,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0] req_start, req_ready, req_valid, req_done, req_busy;
  logic [NREQ*WIDTH-1:0] req_base, req_limit, req_step, req_0, req_1;
`ifdef GEN_ARB_ABORT_EN
  logic [NREQ-1:0] req_abort;
`endif
  logic [WIDTH-1:0] gen_base, gen_limit, gen_step, gen_0, gen_1;
  logic gen_start, gen_reset, gen_ready, gen_valid, gen_done;
  modport master (
    input req_start, req_base, req_limit, req_step, req_ready, gen_0, gen_1, gen_valid, gen_done,
`ifdef GEN_ARB_ABORT_EN
    input req_abort,
`endif
    output req_0, req_1, req_valid, req_done, req_busy, gen_base, gen_limit, gen_step, gen_start,
    output gen_reset, gen_ready
  );
  modport slave (
    output req_start, req_base, req_limit, req_step, req_ready, gen_0, gen_1, gen_valid, gen_done,
`ifdef GEN_ARB_ABORT_EN
    output req_abort,
`endif
    input req_0, req_1, req_valid, req_done, req_busy, gen_base, gen_limit, gen_step, gen_start,
    input gen_reset, gen_ready
  );
endinterface

// File: rtl/gen_call_arbiter.sv
// gen_call_arbiter: round-robin sharing of one ready/valid/done generator among NREQ callers
// Define GEN_ARB_ABORT_EN to add req_abort (drop a pending call or abort the active one).
module gen_call_arbiter #(
  parameter int NREQ = 2,
  parameter int WIDTH = 32
) (
  input logic _clock,
  input logic _reset_n,
  gen_call_arbiter_if.master bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, START, STREAM, FINISH} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] pending, busy, abort, pend_abort, avail, done_q;
  logic [WIDTH-1:0] base_q [NREQ];
  logic [WIDTH-1:0] limit_q [NREQ];
  logic [WIDTH-1:0] step_q [NREQ];
  logic [WIDTH-1:0] gb, gl, gs, out_0, out_1;
  logic [PW-1:0] rr_ptr, owner, grant, owner_nxt;
  logic found, out_valid, gen_start_q, gen_rst_q, abort_owner, grant_fire, finish, capture;
  int idx;
`ifdef GEN_ARB_ABORT_EN
  assign abort = bus.req_abort;
`else
  assign abort = '0;
`endif
  assign pend_abort = abort & pending;
  assign avail = pending & ~abort;
  assign abort_owner = abort[owner] && state != IDLE;
  assign grant_fire = state == IDLE && found;
  assign finish = state == FINISH && !out_valid;
  assign owner_nxt = owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
  assign capture = bus.gen_ready && bus.gen_valid;
  assign bus.gen_ready = state == STREAM && (!out_valid || bus.req_ready[owner]);
  assign bus.gen_start = gen_start_q;
  assign bus.gen_reset = !_reset_n || gen_rst_q;
  assign bus.gen_base = gb;
  assign bus.gen_limit = gl;
  assign bus.gen_step = gs;
  assign bus.req_done = done_q;
  assign bus.req_busy = busy;
  always_comb begin
    busy = pending;
    for (int i = 0; i < NREQ; i++) busy[i] = pending[i] | (owner == PW'(i) && state != IDLE);
  end
  // scan from rr_ptr upward with wrap; the last hit in descending order is the nearest one
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= NREQ ? idx - NREQ : idx;
      if (avail[PW'(idx)]) begin
        grant = PW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = abort_owner ? IDLE
            : state == IDLE ? (found ? START : IDLE)
            : state == START ? STREAM
            : state == STREAM ? (bus.gen_done ? FINISH : STREAM)
            : finish ? IDLE : FINISH;
  end
  always_comb begin
    bus.req_valid = '0;
    bus.req_0 = '0;
    bus.req_1 = '0;
    bus.req_valid[owner] = out_valid;
    bus.req_0[int'(owner)*WIDTH +: WIDTH] = out_0;
    bus.req_1[int'(owner)*WIDTH +: WIDTH] = out_1;
  end
  always_ff @(posedge _clock) begin
    if (!_reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      pending <= '0;
      done_q <= '0;
      rr_ptr <= '0;
      owner <= '0;
      out_valid <= 1'b0;
      out_0 <= '0;
      out_1 <= '0;
      gb <= '0;
      gl <= '0;
      gs <= '0;
      gen_start_q <= 1'b0;
      gen_rst_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_start[i] && !busy[i]) begin
          pending[i] <= 1'b1;
          base_q[i] <= bus.req_base[i*WIDTH +: WIDTH];
          limit_q[i] <= bus.req_limit[i*WIDTH +: WIDTH];
          step_q[i] <= bus.req_step[i*WIDTH +: WIDTH];
        end
        if (pend_abort[i] || (grant_fire && grant == PW'(i))) pending[i] <= 1'b0;
      end
      done_q <= pend_abort;
      if (finish || abort_owner) begin
        done_q[owner] <= 1'b1;
        rr_ptr <= owner_nxt;
      end
      if (grant_fire) begin
        owner <= grant;
        gb <= base_q[grant];
        gl <= limit_q[grant];
        gs <= step_q[grant];
      end
      gen_start_q <= grant_fire;
      gen_rst_q <= abort_owner;
      if (abort_owner) begin
        out_valid <= 1'b0;
        out_0 <= '0;
        out_1 <= '0;
      end else if (capture) begin
        out_valid <= 1'b1;
        out_0 <= bus.gen_0;
        out_1 <= bus.gen_1;
      end else if (bus.req_ready[owner]) out_valid <= 1'b0;
    end
  end
endmodule
